// File: rtl/ucisc_ctrl_pkg.sv
// Shared types and constants for the uCISC control sequencer.
package ucisc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SRC_READ,
        EXECUTE,
        WRITE_MEM,
        COMMIT
    } state_t;

    // Instruction field bit positions
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned IMM_W     = 7;
    localparam int unsigned SRC_LSB   = 7;
    localparam int unsigned DST_LSB   = 10;
    localparam int unsigned SEL_W     = 3;
    localparam int unsigned INC_BIT   = 13;
    localparam int unsigned DEC_BIT   = 14;
    localparam int unsigned STORE_BIT = 15;

    // Register-block select codes with special meaning
    localparam logic [2:0] SEL_PC    = 3'd0;
    localparam logic [2:0] SEL_FLAGS = 3'd4;

    // Selects 1-3 use r1-r3 as a memory pointer
    function automatic logic is_mem_mode(input logic [2:0] sel);
        return (sel >= 3'd1) && (sel <= 3'd3);
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational decode of the latched instruction into selects and strobe qualifiers.
module instr_field_decode
    import ucisc_ctrl_pkg::*;
(
    input  logic [15:0] instr,
    output logic [2:0]  src_sel,
    output logic [2:0]  dst_sel,
    output logic [6:0]  imm,
    output logic        dec,
    output logic        src_imm,
    output logic        src_mem,
    output logic        mem_store,
    output logic        store_reg,
    output logic        flag_update,
    output logic        pc_jump,
    output logic        push,
    output logic        post_inc
);

    logic inc;
    logic store;

    // Field extraction and per-instruction strobe qualifiers
    always_comb begin
        src_sel     = instr[SRC_LSB +: SEL_W];
        dst_sel     = instr[DST_LSB +: SEL_W];
        imm         = instr[IMM_LSB +: IMM_W];
        inc         = instr[INC_BIT];
        dec         = instr[DEC_BIT];
        store       = instr[STORE_BIT];
        src_imm     = (src_sel == SEL_FLAGS);
        src_mem     = is_mem_mode(src_sel);
        mem_store   = store && is_mem_mode(dst_sel);
        store_reg   = store && (dst_sel >= 3'd4);
        flag_update = store && (dst_sel != SEL_FLAGS);
        pc_jump     = store && (dst_sel == SEL_PC);
        push        = inc && dec;
        post_inc    = inc && !dec;
    end

endmodule

// File: rtl/register_sequencer.sv
// Multi-cycle fetch / source-read / execute / write / commit sequencer for the uCISC core.
module register_sequencer
    import ucisc_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] pc,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [2:0]       source_select,
    output logic [2:0]       destination_select,
    output logic             source_immediate,
    output logic [6:0]       immediate,
    output logic             pre_increment,
    output logic             post_increment,
    output logic             decrement,
    output logic             store_value,
    output logic             set_flags,
    output logic [WIDTH-1:0] destination_write,
    input  logic [WIDTH-1:0] source_out,
    input  logic [WIDTH-1:0] destination_out,
    output logic [WIDTH-1:0] operand_value,
    input  logic [WIDTH-1:0] alu_result,
    output logic             pc_advance,
    output logic             pc_load,
    output logic             busy
);

    state_t           state;
    logic [15:0]      instr;
    logic [WIDTH-1:0] operand_reg;
    logic [WIDTH-1:0] result_reg;

    logic [2:0] d_src_sel;
    logic [2:0] d_dst_sel;
    logic [6:0] d_imm;
    logic       d_dec;
    logic       d_src_imm;
    logic       d_src_mem;
    logic       d_mem_store;
    logic       d_store_reg;
    logic       d_flag_update;
    logic       d_pc_jump;
    logic       d_push;
    logic       d_post_inc;

    instr_field_decode u_decode (
        .instr       (instr),
        .src_sel     (d_src_sel),
        .dst_sel     (d_dst_sel),
        .imm         (d_imm),
        .dec         (d_dec),
        .src_imm     (d_src_imm),
        .src_mem     (d_src_mem),
        .mem_store   (d_mem_store),
        .store_reg   (d_store_reg),
        .flag_update (d_flag_update),
        .pc_jump     (d_pc_jump),
        .push        (d_push),
        .post_inc    (d_post_inc)
    );

    // State sequencing and instruction/operand/result latching
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            instr       <= '0;
            operand_reg <= '0;
            result_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) state <= FETCH;
                end
                FETCH: begin
                    if (mem_ack) begin
                        instr <= mem_rdata[15:0];
                        state <= is_mem_mode(mem_rdata[SRC_LSB +: SEL_W]) ? SRC_READ : EXECUTE;
                    end
                end
                SRC_READ: begin
                    if (mem_ack) begin
                        operand_reg <= mem_rdata;
                        state       <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    result_reg <= alu_result;
                    state      <= d_mem_store ? WRITE_MEM : COMMIT;
                end
                WRITE_MEM: begin
                    if (mem_ack) state <= COMMIT;
                end
                COMMIT: begin
                    state <= run ? FETCH : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decoded from the registered state; the FETCH address must follow
    // the PC updated on the COMMIT edge, so it cannot be pre-registered.
    always_comb begin
        mem_req            = 1'b0;
        mem_we             = 1'b0;
        mem_addr           = '0;
        mem_wdata          = '0;
        source_select      = '0;
        destination_select = '0;
        source_immediate   = 1'b0;
        immediate          = '0;
        pre_increment      = 1'b0;
        post_increment     = 1'b0;
        decrement          = 1'b0;
        store_value        = 1'b0;
        set_flags          = 1'b0;
        destination_write  = '0;
        operand_value      = '0;
        pc_advance         = 1'b0;
        pc_load            = 1'b0;
        busy               = (state != IDLE);

        if (state != IDLE && state != FETCH) begin
            source_select      = d_src_sel;
            destination_select = d_dst_sel;
            source_immediate   = d_src_imm;
            immediate          = d_imm;
            decrement          = d_dec;
        end

        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            SRC_READ: begin
                mem_req  = 1'b1;
                mem_addr = source_out;
            end
            EXECUTE: begin
                operand_value = d_src_mem ? operand_reg : source_out;
            end
            WRITE_MEM: begin
                mem_req       = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = destination_out;
                mem_wdata     = result_reg;
                pre_increment = d_push;
            end
            COMMIT: begin
                destination_write = result_reg;
                store_value       = d_store_reg;
                set_flags         = d_flag_update;
                post_increment    = d_post_inc;
                pc_load           = d_pc_jump;
                pc_advance        = !d_pc_jump;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_register_sequencer.sv
// Scoreboard bench for register_sequencer: directed instructions, expected
// memory handshakes and commit pulses queued ahead, checked by a monitor.
module tb_register_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] pc;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [2:0]  source_select;
    logic [2:0]  destination_select;
    logic        source_immediate;
    logic [6:0]  immediate;
    logic        pre_increment;
    logic        post_increment;
    logic        decrement;
    logic        store_value;
    logic        set_flags;
    logic [15:0] destination_write;
    logic [15:0] source_out;
    logic [15:0] destination_out;
    logic [15:0] operand_value;
    logic [15:0] alu_result;
    logic        pc_advance;
    logic        pc_load;
    logic        busy;

    register_sequencer #(.WIDTH(16)) dut (
        .clock              (clock),
        .reset              (reset),
        .run                (run),
        .pc                 (pc),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata),
        .source_select      (source_select),
        .destination_select (destination_select),
        .source_immediate   (source_immediate),
        .immediate          (immediate),
        .pre_increment      (pre_increment),
        .post_increment     (post_increment),
        .decrement          (decrement),
        .store_value        (store_value),
        .set_flags          (set_flags),
        .destination_write  (destination_write),
        .source_out         (source_out),
        .destination_out    (destination_out),
        .operand_value      (operand_value),
        .alu_result         (alu_result),
        .pc_advance         (pc_advance),
        .pc_load            (pc_load),
        .busy               (busy)
    );

    always #5 clock = ~clock;

    // Environment: ALU adds one to the operand, PC register, memory with per-address wait states
    logic [15:0] mem_img [0:1023];
    logic [15:0] pc_init;
    logic [15:0] slow_addr;
    int unsigned slow_wait;
    int unsigned need_wait;
    int unsigned wcnt;
    logic        stray_ack;
    int          cyc;

    assign alu_result = operand_value + 16'h0001;
    assign need_wait  = (mem_addr == slow_addr) ? slow_wait : 0;
    assign mem_ack    = (mem_req && (wcnt == need_wait)) || stray_ack;
    assign mem_rdata  = mem_img[mem_addr[9:0]];

    always_ff @(posedge clock) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    always_ff @(posedge clock) begin
        if (reset)           pc <= pc_init;
        else if (pc_load)    pc <= destination_write;
        else if (pc_advance) pc <= pc + 16'h0001;
    end

    always_ff @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic        is_commit;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        pre_inc;
        logic [15:0] dw;
        logic        sv;
        logic        sf;
        logic        pi;
        logic        pl;
        logic        pa;
        logic [2:0]  dst;
        logic [2:0]  src;
        logic [6:0]  imm;
        logic        simm;
        logic        dec;
    } ev_t;

    typedef struct {
        ev_t ev;
        int  gap;
        int  hold;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_commits = 0;
    int   last_evt = 0;

    function automatic exp_t mk_mem(input logic we, input logic [15:0] a, input logic [15:0] wd,
                                    input logic pre, input int gap, input int hold);
        exp_t e;
        e.ev         = '0;
        e.ev.we      = we;
        e.ev.addr    = a;
        e.ev.wdata   = wd;
        e.ev.pre_inc = pre;
        e.gap        = gap;
        e.hold       = hold;
        return e;
    endfunction

    function automatic exp_t mk_commit(input logic [15:0] dw, input logic sv, input logic sf,
                                       input logic pi, input logic pl, input logic pa,
                                       input logic [2:0] dst, input logic [2:0] src,
                                       input logic [6:0] imm, input logic simm, input logic dec,
                                       input int gap);
        exp_t e;
        e.ev           = '0;
        e.ev.is_commit = 1'b1;
        e.ev.dw        = dw;
        e.ev.sv        = sv;
        e.ev.sf        = sf;
        e.ev.pi        = pi;
        e.ev.pl        = pl;
        e.ev.pa        = pa;
        e.ev.dst       = dst;
        e.ev.src       = src;
        e.ev.imm       = imm;
        e.ev.simm      = simm;
        e.ev.dec       = dec;
        e.gap          = gap;
        e.hold         = 0;
        return e;
    endfunction

    task automatic check_event(input string kind, input ev_t got, input int hold_got);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected event: got=%h expected none", kind, got);
        end else begin
            e = sb.pop_front();
            if (got !== e.ev) begin
                n_fail++;
                $display("FAIL %s fields: got=%h expected=%h", kind, got, e.ev);
            end
            if (e.gap >= 0) begin
                n_checks++;
                if (cyc - last_evt != e.gap) begin
                    n_fail++;
                    $display("FAIL %s latency: got=%0d expected=%0d cycles", kind, cyc - last_evt, e.gap);
                end
            end
            if (e.hold > 0) begin
                n_checks++;
                if (hold_got != e.hold) begin
                    n_fail++;
                    $display("FAIL %s req_hold: got=%0d expected=%0d cycles", kind, hold_got, e.hold);
                end
            end
        end
        last_evt = cyc;
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard at each handshake or commit
    initial begin : monitor
        logic        req_open;
        logic [33:0] held;
        int          hold_cnt;
        ev_t         got;
        req_open = 1'b0;
        held     = '0;
        hold_cnt = 0;
        forever begin
            @(negedge clock);
            if (mem_req) begin
                if (req_open) begin
                    n_checks++;
                    if ({mem_we, mem_addr, mem_wdata} !== held) begin
                        n_fail++;
                        $display("FAIL mem_stable: got=%h expected=%h", {mem_we, mem_addr, mem_wdata}, held);
                    end
                end else begin
                    req_open = 1'b1;
                    held     = {mem_we, mem_addr, mem_wdata};
                    hold_cnt = 0;
                end
                hold_cnt++;
                if (mem_ack) begin
                    got         = '0;
                    got.we      = mem_we;
                    got.addr    = mem_addr;
                    got.wdata   = mem_wdata;
                    got.pre_inc = pre_increment;
                    check_event("mem", got, hold_cnt);
                    req_open = 1'b0;
                end
            end else begin
                req_open = 1'b0;
            end
            if (pc_advance || pc_load) begin
                got           = '0;
                got.is_commit = 1'b1;
                got.dw        = destination_write;
                got.sv        = store_value;
                got.sf        = set_flags;
                got.pi        = post_increment;
                got.pl        = pc_load;
                got.pa        = pc_advance;
                got.dst       = destination_select;
                got.src       = source_select;
                got.imm       = immediate;
                got.simm      = source_immediate;
                got.dec       = decrement;
                n_commits++;
                check_event("commit", got, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [15:0] p);
        pc_init = p;
        reset   = 1'b1;
        run     = 1'b0;
        tick();
        tick();
        reset   = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        logic [87:0] v;
        v = {mem_req, mem_we, mem_addr, mem_wdata, source_select, destination_select,
             source_immediate, immediate, pre_increment, post_increment, decrement,
             store_value, set_flags, destination_write, operand_value, pc_advance, pc_load, busy};
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs=%h expected all zero", name, v);
        end
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 200) begin
            tick();
            t++;
        end
        n_checks++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL %s timeout: pending=%0d busy=%0b expected 0 and 0", name, sb.size(), busy);
        end
    endtask

    // Run n instructions: run stays high until the last one has been fetched
    task automatic go(input int n, input string name);
        int base;
        int t;
        base = n_commits;
        t    = 0;
        run  = 1'b1;
        tick();
        while (n_commits < base + n - 1 && t < 200) begin
            tick();
            t++;
        end
        run = 1'b0;
        wait_done(name);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t;
        for (int i = 0; i < 1024; i++) mem_img[i] = 16'h0000;
        reset           = 1'b1;
        run             = 1'b0;
        pc_init         = 16'h0000;
        slow_addr       = 16'hFFFF;
        slow_wait       = 0;
        stray_ack       = 1'b0;
        source_out      = 16'h0000;
        destination_out = 16'h0000;
        cyc             = 0;

        // Reset state
        do_reset(16'h0000);
        chk_idle("reset_state");

        // Reg->reg back to back: store, dst=5, src=4(imm), imm=1
        mem_img[16'h0010] = 16'h9601;
        mem_img[16'h0011] = 16'h9601;
        source_out = 16'h0041;
        do_reset(16'h0010);
        sb.push_back(mk_mem(1'b0, 16'h0010, 16'h0000, 1'b0, -1, 1));
        sb.push_back(mk_commit(16'h0042, 1, 1, 0, 0, 1, 3'd5, 3'd4, 7'd1, 1, 0, 2));
        sb.push_back(mk_mem(1'b0, 16'h0011, 16'h0000, 1'b0, 1, 1));
        sb.push_back(mk_commit(16'h0042, 1, 1, 0, 0, 1, 3'd5, 3'd4, 7'd1, 1, 0, 2));
        go(2, "reg_reg");

        // Memory source with two wait states
        mem_img[16'h0020] = 16'h9480;
        mem_img[16'h0100] = 16'hBEEF;
        source_out = 16'h0100;
        slow_addr  = 16'h0100;
        slow_wait  = 2;
        do_reset(16'h0020);
        sb.push_back(mk_mem(1'b0, 16'h0020, 16'h0000, 1'b0, -1, 1));
        sb.push_back(mk_mem(1'b0, 16'h0100, 16'h0000, 1'b0, 3, 3));
        sb.push_back(mk_commit(16'hBEF0, 1, 1, 0, 0, 1, 3'd5, 3'd1, 7'd0, 0, 0, 2));
        go(1, "mem_src_wait");
        slow_addr = 16'hFFFF;
        slow_wait = 0;

        // Push: store, inc, dec, dst=2, src=imm
        mem_img[16'h0040] = 16'hEA05;
        source_out      = 16'h0010;
        destination_out = 16'h00FF;
        do_reset(16'h0040);
        sb.push_back(mk_mem(1'b0, 16'h0040, 16'h0000, 1'b0, -1, 1));
        sb.push_back(mk_mem(1'b1, 16'h00FF, 16'h0011, 1'b1, 2, 1));
        sb.push_back(mk_commit(16'h0011, 0, 1, 0, 0, 1, 3'd2, 3'd4, 7'd5, 1, 1, 1));
        go(1, "push");

        // Jump to 0x0200, then a post-increment instruction fetched from there
        mem_img[16'h0050] = 16'h8200;
        mem_img[16'h0200] = 16'h2A00;
        source_out = 16'h01FF;
        do_reset(16'h0050);
        sb.push_back(mk_mem(1'b0, 16'h0050, 16'h0000, 1'b0, -1, 1));
        sb.push_back(mk_commit(16'h0200, 0, 1, 0, 1, 0, 3'd0, 3'd4, 7'd0, 1, 0, 2));
        sb.push_back(mk_mem(1'b0, 16'h0200, 16'h0000, 1'b0, 1, 1));
        sb.push_back(mk_commit(16'h0200, 0, 0, 1, 0, 1, 3'd2, 3'd4, 7'd0, 1, 0, 2));
        go(2, "jump");

        // Memory to memory: src=3, dst=1, store
        mem_img[16'h0070] = 16'h8580;
        mem_img[16'h0300] = 16'h1234;
        source_out      = 16'h0300;
        destination_out = 16'h03C0;
        do_reset(16'h0070);
        sb.push_back(mk_mem(1'b0, 16'h0070, 16'h0000, 1'b0, -1, 1));
        sb.push_back(mk_mem(1'b0, 16'h0300, 16'h0000, 1'b0, 1, 1));
        sb.push_back(mk_mem(1'b1, 16'h03C0, 16'h1235, 1'b0, 2, 1));
        sb.push_back(mk_commit(16'h1235, 0, 1, 0, 0, 1, 3'd1, 3'd3, 7'd0, 0, 0, 1));
        go(1, "mem_mem");

        // Run dropped during EXECUTE: store to flags
        mem_img[16'h0060] = 16'h9203;
        mem_img[16'h0061] = 16'h9203;
        source_out = 16'h0041;
        do_reset(16'h0060);
        sb.push_back(mk_mem(1'b0, 16'h0060, 16'h0000, 1'b0, -1, 1));
        sb.push_back(mk_commit(16'h0042, 1, 0, 0, 0, 1, 3'd4, 3'd4, 7'd3, 1, 0, 2));
        run = 1'b1;
        t = 0;
        tick();
        while (!(busy && !mem_req && !pc_advance && !pc_load) && t < 50) begin
            tick();
            t++;
        end
        run = 1'b0;
        wait_done("run_drop");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_idle("run_drop_idle");
        end

        // Reset during a pending source read, with a stray ack one cycle later
        mem_img[16'h0030] = 16'h9480;
        source_out = 16'h0100;
        slow_addr  = 16'h0100;
        slow_wait  = 10;
        do_reset(16'h0030);
        sb.push_back(mk_mem(1'b0, 16'h0030, 16'h0000, 1'b0, -1, 1));
        run = 1'b1;
        t = 0;
        tick();
        while (!(mem_req && mem_addr == 16'h0100) && t < 50) begin
            tick();
            t++;
        end
        n_checks++;
        if (t >= 50) begin
            n_fail++;
            $display("FAIL reset_abort setup timeout: mem_addr=%h expected 0100", mem_addr);
        end
        reset = 1'b1;
        run   = 1'b0;
        tick();
        reset     = 1'b0;
        stray_ack = 1'b1;
        chk_idle("reset_abort");
        tick();
        stray_ack = 1'b0;
        chk_idle("late_ack_ignored");
        tick();
        chk_idle("after_late_ack");
        slow_addr = 16'hFFFF;
        slow_wait = 0;

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending=%0d expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_sequencer.md
# register_sequencer

Multi-cycle control FSM that drives the shared register block of the single-issue uCISC core. It sequences each instruction through fetch, optional memory source read, execute and optional memory destination write over one shared memory port. It also generates every register-block strobe: selects, immediate, pre/post increment, store and flag update. It sits between the memory arbiter port and the register block/ALU pair, and owns instruction latching and PC advance.

## Interface
Parameters:
- `WIDTH`, 16, data/address width; the core fixes it at 16

Ports:
- `clock`  in  1  core clock
- `reset`  in  1  synchronous, active-high
- `run`  in  1  1 = keep executing; 0 = stop at next instruction boundary
- `pc`  in  16  current PC, from the PC register
- `mem_req`  out  1  memory request, held until ack
- `mem_we`  out  1  1 = write
- `mem_addr`  out  16  request address
- `mem_wdata`  out  16  write data
- `mem_ack`  in  1  request accepted/completed this cycle
- `mem_rdata`  in  16  read data, valid with `mem_ack`
- `source_select`, `destination_select`  out  3  register-block selects
- `source_immediate`  out  1  high when source_select==4
- `immediate`  out  7  instruction bits [6:0]
- `pre_increment`, `post_increment`, `decrement`  out  1  register-block strobes
- `store_value`, `set_flags`  out  1  register-block write strobes
- `destination_write`  out  16  result to register block/PC
- `source_out`, `destination_out`  in  16  register-block address/value outputs
- `operand_value`  out  16  source operand to ALU
- `alu_result`  in  16  combinational ALU result
- `pc_advance`  out  1  pulse: PC += 1
- `pc_load`  out  1  pulse: PC <= destination_write
- `busy`  out  1  high in any state except IDLE

## Operation
- Instruction fields, latched in `instr`: [6:0] imm, [9:7] src, [12:10] dst, [13] inc, [14] dec, [15] store.
- Memory modes: select 1–3 (r1–r3 as pointer). Register modes: 0 (pc), 4 (flags/imm), 5–7.
- States:
  - IDLE: go to FETCH when `run`.
  - FETCH: req, addr=`pc`, we=0. On ack, latch `instr`. Go to SRC_READ if src is a memory mode, else EXECUTE.
  - SRC_READ: req, addr=`source_out`. On ack, latch `operand_reg`, then go to EXECUTE.
  - EXECUTE: `operand_value` = src memory mode ? `operand_reg` : `source_out`. Latch `result_reg`<=`alu_result`. Go to WRITE_MEM if store and dst is a memory mode, else COMMIT.
  - WRITE_MEM: req, we=1, addr=`destination_out`, wdata=`result_reg`, `pre_increment`=inc&dec (push). On ack, go to COMMIT.
  - COMMIT, one cycle:
    - `destination_write`=`result_reg`.
    - `store_value`=store & dst∉{0,1,2,3}.
    - `set_flags`=store & dst≠4.
    - `post_increment`=inc&~dec.
    - If store&dst==0: `pc_load`=1 and `pc_advance`=0; otherwise `pc_advance`=1.
    - Next state: FETCH if `run`, else IDLE.
- Selects, `immediate` and `decrement` are driven from `instr` in every state except IDLE/FETCH; they are 0 in IDLE/FETCH.
- `run` deasserted mid-instruction has no effect until COMMIT completes.
- Reset (any state, including mid-request):
  - state=IDLE; `instr`, `operand_reg`, `result_reg` = 0.
  - `mem_req` drops the next cycle; the pending transaction is abandoned and a late ack is ignored.
  - All strobes are 0.

## Timing
- Reset values: all outputs 0; `busy`=0.
- `mem_ack` is sampled at posedge while `mem_req`=1. Same-cycle ack is legal, giving a zero-wait access of 1 cycle. `mem_addr`/`mem_we`/`mem_wdata` are stable while `mem_req` is high.
- Latency with zero-wait memory, IDLE excluded:
  - reg→reg: 3 cycles (FETCH, EXECUTE, COMMIT).
  - mem source: +1 cycle.
  - mem destination: +1 cycle.
  - mem→mem: 5 cycles.
  - Each wait state adds 1 cycle.
- COMMIT strobes are single-cycle pulses. The register block commits on the same edge that leaves COMMIT.
- `mem_req` is never asserted in EXECUTE or COMMIT.
- Back-to-back instructions: COMMIT is followed directly by FETCH, with no bubble. FETCH uses the PC as updated at the COMMIT edge.

## Structure
- Package `ucisc_ctrl_pkg`:
  - state enum (IDLE, FETCH, SRC_READ, EXECUTE, WRITE_MEM, COMMIT)
  - instruction field bit positions
  - select constants (SEL_PC=0, SEL_FLAGS=4) and `is_mem_mode()`
- One sub-module: `instr_field_decode`, a combinational block that maps `instr` to selects, mode flags and strobe qualifiers. The FSM and its registers stay in `register_sequencer`.

## Test plan
- Reg→reg: instr 0x9601 (store, dst=5, src=4, imm=1), `alu_result`=0x0042, zero-wait memory:
  - FETCH, EXECUTE, COMMIT with `store_value`=1 and `destination_write`=0x0042 in cycle 3.
  - `pc_advance`=1.
  - Next FETCH in cycle 4.
- Mem source, 2 wait states: src=1, `source_out`=0x0100, `mem_rdata`=0xBEEF:
  - `mem_addr`=0x0100 held 3 cycles.
  - `operand_value`=0xBEEF in EXECUTE.
- Push: store=1, inc=1, dec=1, dst=2:
  - WRITE_MEM with `pre_increment`=1, `mem_we`=1, `mem_wdata`=`result_reg`.
  - `store_value`=0 in COMMIT.
- Jump: store=1, dst=0, result 0x0200:
  - COMMIT asserts `pc_load`=1 and `pc_advance`=0.
  - Next FETCH `mem_addr`=0x0200.
- Reset asserted in SRC_READ while `mem_req`=1, with ack arriving 1 cycle later:
  - `mem_req`=0 next cycle; state IDLE; ack ignored; all strobes 0.
- `run` dropped during EXECUTE:
  - The instruction completes through COMMIT, then the FSM enters IDLE with `busy`=0 and no further `mem_req`.
